// File: rtl/refresh_scheduler.sv
// Periodic refresh scheduler: a programmable prescaler grants one of four requesters per terminal count.
// Optional build macro REFRESH_FIXED_PRIO_EN selects fixed priority (ch0 highest) instead of round-robin.
module refresh_scheduler #(
  parameter int unsigned DW = 8,
  parameter int unsigned PW = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [PW-1:0]    period,
  input  logic [3:0]       req,
  input  logic [4*DW-1:0]  req_data,
  output logic [3:0]       grant,
  output logic             out_valid,
  output logic [DW-1:0]    data_out,
  output logic [1:0]       ch_id,
  output logic             busy
);

  localparam int unsigned NCH = 4;
  localparam int unsigned IW  = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    ISSUE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   cnt_q, cnt_d;
  logic [NCH-1:0]  grant_d;
  logic            valid_d;
  logic [DW-1:0]   data_d;
  logic [IW-1:0]   ch_d;

  logic            pick_found;
  logic [IW-1:0]   pick_idx;
  logic [IW-1:0]   cand;

`ifndef REFRESH_FIXED_PRIO_EN
  logic [IW-1:0]   last_q, last_d;
`endif

  // Arbiter: first set request starting after the last served channel (or at ch0 when fixed).
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int i = 0; i < NCH; i++) begin
`ifdef REFRESH_FIXED_PRIO_EN
      cand = IW'(i);
`else
      cand = last_q + IW'(i + 1);
`endif
      if (!pick_found && req[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    grant_d = '0;
    valid_d = 1'b0;
    data_d  = data_out;
    ch_d    = ch_id;
`ifndef REFRESH_FIXED_PRIO_EN
    last_d  = last_q;
`endif
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (enable && (|req)) state_d = COUNT;
      end
      COUNT: begin
        if (enable) begin
          if (cnt_q < period) begin
            cnt_d = cnt_q + PW'(1);
          end else begin
            cnt_d = '0;
            if (pick_found) begin
              grant_d = NCH'(1) << pick_idx;
              data_d  = req_data[pick_idx*DW +: DW];
              ch_d    = pick_idx;
              valid_d = 1'b1;
`ifndef REFRESH_FIXED_PRIO_EN
              last_d  = pick_idx;
`endif
              state_d = ISSUE;
            end else begin
              state_d = IDLE;
            end
          end
        end
      end
      ISSUE: begin
        // The just-granted channel is masked; it drops its request during this cycle.
        cnt_d = '0;
        if (enable && (|(req & ~grant))) state_d = COUNT;
        else                             state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      grant     <= '0;
      out_valid <= 1'b0;
      data_out  <= '0;
      ch_id     <= '0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      grant     <= grant_d;
      out_valid <= valid_d;
      data_out  <= data_d;
      ch_id     <= ch_d;
      busy      <= (state_d != IDLE);
    end
  end

`ifndef REFRESH_FIXED_PRIO_EN
  // Round-robin pointer; reset value makes ch0 the first served.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) last_q <= IW'(3);
    else       last_q <= last_d;
  end
`endif

endmodule

// File: tb/tb_refresh_scheduler.sv
// Scoreboard bench for refresh_scheduler: directed stimulus pushes expected grants,
// a negedge monitor pops and checks them (payload and arrival cycle).
module tb_refresh_scheduler;

  localparam int unsigned DW = 8;
  localparam int unsigned PW = 8;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            enable = 1'b0;
  logic [PW-1:0]   period = '0;
  logic [3:0]      req = '0;
  logic [4*DW-1:0] req_data = {8'h13, 8'h12, 8'h11, 8'h10};
  logic [3:0]      grant;
  logic            out_valid;
  logic [DW-1:0]   data_out;
  logic [1:0]      ch_id;
  logic            busy;

  refresh_scheduler #(.DW(DW), .PW(PW)) dut (
    .clk(clk), .reset(reset), .enable(enable), .period(period),
    .req(req), .req_data(req_data), .grant(grant), .out_valid(out_valid),
    .data_out(data_out), .ch_id(ch_id), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [3:0] grant;
    logic [7:0] data;
    logic [1:0] ch;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_grant(input int ch, input logic [7:0] data, input int at);
    exp_t e;
    e.grant = 4'b0001 << ch;
    e.data  = data;
    e.ch    = 2'(ch);
    e.cyc   = at;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input int max);
    int n;
    n = 0;
    while (!out_valid && n < max) begin
      tick();
      n++;
    end
    if (!out_valid) begin
      tests++;
      fails++;
      $display("FAIL wait_valid: got no out_valid within %0d cycles, required a pulse", max);
    end
  endtask

  // Monitor: every out_valid must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!reset) begin
      if (out_valid) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_valid: got out_valid=1 at cycle %0d, required no pulse", cyc);
        end else begin
          mon_e = sb.pop_front();
          chk("grant", int'(grant), int'(mon_e.grant));
          chk("data_out", int'(data_out), int'(mon_e.data));
          chk("ch_id", int'(ch_id), int'(mon_e.ch));
          chk("valid_cycle", cyc, mon_e.cyc);
        end
      end else begin
        chk("grant_idle", int'(grant), 0);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;

    // Reset state
    tick(); tick();
    chk("rst_grant", int'(grant), 0);
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_data", int'(data_out), 0);
    chk("rst_ch", int'(ch_id), 0);
    chk("rst_busy", int'(busy), 0);
    reset = 1'b0;

    // Single request, period 3
    tick();
    req_data[7:0] = 8'h5A;
    period = 8'd3; enable = 1'b1; req = 4'b0001;
    c = cyc;
    expect_grant(0, 8'h5A, c + 5);
    tick(); tick();
    chk("busy_counting", int'(busy), 1);
    wait_valid(20);
    req = 4'b0000;
    tick();
    chk("busy_drop", int'(busy), 0);
    chk("hold_data_a", int'(data_out), 8'h5A);
    req_data[7:0] = 8'h10;

    // Rotation with all requests held, period 2
    reset = 1'b1; tick(); reset = 1'b0;
    period = 8'd2; req = 4'b1111;
    c = cyc;
    for (int k = 0; k < 5; k++) begin
`ifdef REFRESH_FIXED_PRIO_EN
      expect_grant(0, 8'h10, c + 4 + 4*k);
`else
      expect_grant(k % 4, 8'h10 + 8'(k % 4), c + 4 + 4*k);
`endif
    end
    for (int k = 0; k < 5; k++) begin
      wait_valid(20);
      if (k < 4) tick();
    end
    req = 4'b0000;
    tick();
    chk("busy_after_rot", int'(busy), 0);

    // Enable stall for 3 cycles, period 4
    period = 8'd4; req = 4'b0010;
    c = cyc;
    expect_grant(1, 8'h11, c + 9);
    tick(); tick();
    enable = 1'b0;
    tick();
    chk("stall_data_hold", int'(data_out), 8'h10);
    tick(); tick();
    chk("stall_busy", int'(busy), 1);
    enable = 1'b1;
    wait_valid(20);
    req = 4'b0000;
    tick();

    // Request withdrawn before terminal count
    period = 8'd3; req = 4'b0100;
    tick(); tick(); tick(); tick();
    req = 4'b0000;
    tick(); tick();
    chk("withdraw_busy", int'(busy), 0);
    chk("withdraw_data", int'(data_out), 8'h11);
    chk("withdraw_ch", int'(ch_id), 1);

    // Reset mid-count at cnt=2, period 5
    period = 8'd5; req = 4'b0001;
    tick(); tick(); tick();
    reset = 1'b1;
    #1;
    chk("midrst_grant", int'(grant), 0);
    chk("midrst_valid", int'(out_valid), 0);
    chk("midrst_data", int'(data_out), 0);
    chk("midrst_ch", int'(ch_id), 0);
    chk("midrst_busy", int'(busy), 0);
    req = 4'b0000;
    tick(); tick();
    reset = 1'b0; req = 4'b1111;
    c = cyc;
    expect_grant(0, 8'h10, c + 7);
    wait_valid(20);
    req = 4'b0000;
    tick();

    // Period lowered from 10 to 1 at cnt=6
    period = 8'd10; req = 4'b0010;
    c = cyc;
    expect_grant(1, 8'h11, c + 8);
    for (int k = 0; k < 7; k++) tick();
    period = 8'd1;
    wait_valid(20);
    req = 4'b0000;
    tick();

    // Period 0: single counting cycle
    period = 8'd0; req = 4'b1000;
    c = cyc;
    expect_grant(3, 8'h13, c + 2);
    wait_valid(10);
    req = 4'b0000;
    tick(); tick(); tick();
    chk("final_busy", int'(busy), 0);
    chk("sb_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
